coeff_update_scheduler: RTL

- Sits between the Nios update PIOs (update_control, update_value, x/y/z_coeff_bank) and the 16-tap signal path coefficient store.
- Queues CPU coefficient writes and drains them only while the filter is idle. Expands broadcast writes into per-axis writes.
- Applies bank selections only at sample boundaries, and only when no coefficient writes are outstanding, so no sample is filtered with a half-updated bank.

---
 rtl/coeff_update_scheduler.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/coeff_update_scheduler.sv
// Coefficient update scheduler: queues CPU tap writes, drains them while the
// filter is idle, expands broadcast writes into x/y/z beats, and switches the
// active banks only at sample boundaries when nothing is outstanding.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no broadcast in flight; pops single writes straight to output
// BC_X  | broadcast beat for axis x is on the write port
// BC_Y  | broadcast beat for axis y is on the write port (or waiting)
// BC_Z  | broadcast beat for axis z is on the write port
module coeff_update_scheduler #(
    parameter int DEPTH = 8,
    parameter int CW    = 16
) (
    input  logic                       sys_clk,
    input  logic                       reset_n,
    input  logic                       update_en,
    input  logic [1:0]                 update_axis,
    input  logic [1:0]                 update_bank,
    input  logic [3:0]                 update_index,
    input  logic [CW-1:0]              update_value,
    input  logic [1:0]                 bank_req_x,
    input  logic [1:0]                 bank_req_y,
    input  logic [1:0]                 bank_req_z,
    input  logic                       filter_busy,
    input  logic                       sample_strobe,
    input  logic                       err_clr,
    output logic                       coef_we,
    output logic [1:0]                 coef_axis,
    output logic [1:0]                 coef_bank,
    output logic [3:0]                 coef_index,
    output logic [CW-1:0]              coef_wdata,
    output logic [1:0]                 x_bank,
    output logic [1:0]                 y_bank,
    output logic [1:0]                 z_bank,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       fifo_full,
    output logic                       overflow,
    output logic                       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [1:0]    axis;
        logic [1:0]    bank;
        logic [3:0]    index;
        logic [CW-1:0] value;
    } entry_t;

    typedef enum logic [1:0] {S_IDLE, S_BC_X, S_BC_Y, S_BC_Z} state_t;

    state_t          state_q, state_d;
    logic            en_q, en_d;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            coef_we_q, coef_we_d;
    logic [1:0]      coef_axis_q, coef_axis_d;
    logic [1:0]      coef_bank_q, coef_bank_d;
    logic [3:0]      coef_index_q, coef_index_d;
    logic [CW-1:0]   coef_wdata_q, coef_wdata_d;
    logic [1:0]      x_bank_q, x_bank_d, y_bank_q, y_bank_d, z_bank_q, z_bank_d;

    logic            push_req, push_ok, pop, busy_w;
    entry_t          head;

    // Handshake decode shared by the FIFO, FSM and bank logic.
    always_comb begin
        push_req = update_en & ~en_q;
        push_ok  = push_req && (count_q < DEPTH_CNT);
        pop      = (state_q == S_IDLE) && (count_q != '0) && !filter_busy;
        head     = mem_q[rd_ptr_q];
        busy_w   = (count_q != '0) || (state_q != S_IDLE);
    end

    // Write FIFO bookkeeping; a pop in the same cycle never frees room for a push.
    always_comb begin
        en_d       = update_en;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = '{axis: update_axis, bank: update_bank,
                                index: update_index, value: update_value};
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        if (err_clr) begin
            overflow_d = 1'b0;
        end else if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    // Write-port FSM; the coefficient fields double as the broadcast holding register.
    always_comb begin
        state_d      = state_q;
        coef_we_d    = 1'b0;
        coef_axis_d  = coef_axis_q;
        coef_bank_d  = coef_bank_q;
        coef_index_d = coef_index_q;
        coef_wdata_d = coef_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    coef_we_d    = 1'b1;
                    coef_bank_d  = head.bank;
                    coef_index_d = head.index;
                    coef_wdata_d = head.value;
                    if (head.axis == 2'd3) begin
                        coef_axis_d = 2'd0;
                        state_d     = S_BC_X;
                    end else begin
                        coef_axis_d = head.axis;
                    end
                end
            end
            S_BC_X: begin
                if (!filter_busy) begin
                    coef_we_d   = 1'b1;
                    coef_axis_d = 2'd1;
                    state_d     = S_BC_Y;
                end
            end
            S_BC_Y: begin
                if (!filter_busy) begin
                    coef_we_d   = 1'b1;
                    coef_axis_d = 2'd2;
                    state_d     = S_BC_Z;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bank switch only at a sample boundary with nothing queued or in flight.
    always_comb begin
        x_bank_d = x_bank_q;
        y_bank_d = y_bank_q;
        z_bank_d = z_bank_q;
        if (sample_strobe && !busy_w) begin
            x_bank_d = bank_req_x;
            y_bank_d = bank_req_y;
            z_bank_d = bank_req_z;
        end
    end

    // State registers; reset discards queued entries and any broadcast beats.
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            en_q         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            coef_we_q    <= 1'b0;
            coef_axis_q  <= '0;
            coef_bank_q  <= '0;
            coef_index_q <= '0;
            coef_wdata_q <= '0;
            x_bank_q     <= '0;
            y_bank_q     <= '0;
            z_bank_q     <= '0;
        end else begin
            state_q      <= state_d;
            en_q         <= en_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            coef_we_q    <= coef_we_d;
            coef_axis_q  <= coef_axis_d;
            coef_bank_q  <= coef_bank_d;
            coef_index_q <= coef_index_d;
            coef_wdata_q <= coef_wdata_d;
            x_bank_q     <= x_bank_d;
            y_bank_q     <= y_bank_d;
            z_bank_q     <= z_bank_d;
        end
    end

    assign coef_we    = coef_we_q;
    assign coef_axis  = coef_axis_q;
    assign coef_bank  = coef_bank_q;
    assign coef_index = coef_index_q;
    assign coef_wdata = coef_wdata_q;
    assign x_bank     = x_bank_q;
    assign y_bank     = y_bank_q;
    assign z_bank     = z_bank_q;
    assign fifo_count = count_q;
    assign fifo_full  = (count_q == DEPTH_CNT);
    assign overflow   = overflow_q;
    assign busy       = busy_w;

endmodule
